// File: rtl/monkey_pkg.sv
// monkey_pkg: shared state encoding and parameter defaults for the monkey action controller
package monkey_pkg;

    typedef enum logic [2:0] {
        GROUND    = 3'd0,
        ROPE      = 3'd1,
        AIR       = 3'd2,
        DYING     = 3'd3,
        RESPAWN   = 3'd4,
        GAME_OVER = 3'd5
    } state_e;

    localparam int FALL_DEATH_PX_DEF = 96;
    localparam int FLOOR_Y_DEF       = 440;
    localparam int DEATH_FRAMES_DEF  = 60;
    localparam int INVULN_FRAMES_DEF = 90;
    localparam int START_LIVES_DEF   = 3;
    localparam int CNT_W             = 7;
    localparam logic signed [10:0] APEX_INIT = 11'sd185;

endpackage

// File: rtl/monkey_action_ctrl_if.sv
// monkey_action_ctrl_if: raw key inputs and gated movement commands
interface monkey_action_ctrl_if;

    logic leftPressed, rightPressed, upPressed, downPressed;
    logic leftCmd, rightCmd, upCmd, downCmd;

    modport master (
        output leftPressed, rightPressed, upPressed, downPressed,
        input  leftCmd, rightCmd, upCmd, downCmd
    );

    modport slave (
        input  leftPressed, rightPressed, upPressed, downPressed,
        output leftCmd, rightCmd, upCmd, downCmd
    );

endinterface

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable per-frame down counter that stops at zero
module frame_down_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // load wins over counting; counting halts once zero is reached
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/monkey_action_ctrl.sv
// monkey_action_ctrl: life/death state machine gating the monkey's movement keys
module monkey_action_ctrl
    import monkey_pkg::*;
#(
    parameter int FALL_DEATH_PX = FALL_DEATH_PX_DEF,
    parameter int FLOOR_Y       = FLOOR_Y_DEF,
    parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
    parameter int START_LIVES   = START_LIVES_DEF
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                restartPressed,
    input  logic                onRope,
    input  logic                onLedge,
    input  logic                collision,
    input  logic                hitEnemy,
    input  logic signed [10:0]  topLeftY,
    monkey_action_ctrl_if.slave keys,
    output logic                moveResetN,
    output logic [2:0]          state,
    output logic [1:0]          lives,
    output logic                invincible,
    output logic                gameOver
);

    state_e              state_q;
    logic signed [10:0]  apex_q;
    logic [1:0]          lives_q;
    logic                enemy_q, mvrst_q;
    logic                footing, active, hit, off_screen, fall_big, die_d;
    logic                death_zero, inv_zero;
    logic signed [11:0]  fall;

    assign footing    = onRope | (onLedge & collision);
    assign active     = state_q inside {GROUND, ROPE, AIR};
    assign hit        = enemy_q | (hitEnemy & ~invincible);
    assign off_screen = topLeftY > $signed(11'(FLOOR_Y));
    assign fall       = {topLeftY[10], topLeftY} - {apex_q[10], apex_q};
    assign fall_big   = fall > $signed(12'(FALL_DEATH_PX));
    assign die_d      = active & (hit | off_screen | ((state_q == AIR) & footing & fall_big));

    frame_down_counter #(.W(CNT_W)) u_death (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (startOfFrame & die_d),
        .load_val_i (CNT_W'(DEATH_FRAMES - 1)),
        .en_i       (startOfFrame & (state_q == DYING)),
        .zero_o     (death_zero)
    );

    // the invulnerability window starts on the one-clk respawn pulse
    frame_down_counter #(.W(CNT_W)) u_inv (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (~mvrst_q),
        .load_val_i (CNT_W'(INVULN_FRAMES)),
        .en_i       (startOfFrame),
        .zero_o     (inv_zero)
    );

    // frame-synchronous game state, fall tracking, lives and respawn pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= AIR;
            apex_q  <= APEX_INIT;
            lives_q <= 2'(START_LIVES);
            enemy_q <= 1'b0;
            mvrst_q <= 1'b1;
        end else begin
            mvrst_q <= 1'b1;
            enemy_q <= startOfFrame ? 1'b0 : (enemy_q | (hitEnemy & ~invincible));
            if (startOfFrame) begin
                case (state_q)
                    GROUND, ROPE, AIR: begin
                        if (die_d) begin
                            state_q <= DYING;
                            lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                        end else if (onRope)
                            state_q <= ROPE;
                        else if (footing)
                            state_q <= GROUND;
                        else begin
                            state_q <= AIR;
                            apex_q  <= (state_q != AIR || topLeftY < apex_q) ? topLeftY : apex_q;
                        end
                    end
                    DYING: begin
                        if (death_zero) begin
                            state_q <= (lives_q == 2'd0) ? GAME_OVER : RESPAWN;
                            mvrst_q <= (lives_q == 2'd0);
                        end
                    end
                    RESPAWN: begin
                        state_q <= AIR;
                        apex_q  <= topLeftY;
                    end
                    GAME_OVER: begin
                        if (restartPressed) begin
                            state_q <= RESPAWN;
                            lives_q <= 2'(START_LIVES);
                            mvrst_q <= 1'b0;
                        end
                    end
                    default: state_q <= AIR;
                endcase
            end
        end
    end

    assign keys.leftCmd  = keys.leftPressed  & active;
    assign keys.rightCmd = keys.rightPressed & active;
    assign keys.upCmd    = keys.upPressed    & ((state_q == GROUND) | (state_q == ROPE));
    assign keys.downCmd  = keys.downPressed  & (state_q == ROPE);

    assign moveResetN = mvrst_q;
    assign state      = state_q;
    assign lives      = lives_q;
    assign invincible = ~inv_zero;
    assign gameOver   = (state_q == GAME_OVER);

endmodule

// File: tb/tb_monkey_action_ctrl.sv
// tb_monkey_action_ctrl: directed table and sequence checks for monkey_action_ctrl
module tb_monkey_action_ctrl;

    localparam logic [2:0] S_GROUND = 3'd0, S_ROPE = 3'd1, S_AIR = 3'd2,
                           S_DYING = 3'd3, S_RESPAWN = 3'd4, S_GAME_OVER = 3'd5;

    logic clk = 1'b0;
    logic resetN, startOfFrame, restartPressed, onRope, onLedge, collision, hitEnemy;
    logic signed [10:0] topLeftY;
    logic moveResetN, invincible, gameOver;
    logic [2:0] state;
    logic [1:0] lives;
    int errors = 0, checks = 0, lows = 0, l0;

    monkey_action_ctrl_if kif ();

    monkey_action_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .restartPressed(restartPressed),
        .onRope(onRope), .onLedge(onLedge), .collision(collision), .hitEnemy(hitEnemy),
        .topLeftY(topLeftY), .keys(kif.slave), .moveResetN(moveResetN), .state(state),
        .lives(lives), .invincible(invincible), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!moveResetN) lows++;

    typedef struct {
        logic rope, ledge, coll;
        int y;
        logic [2:0] st;
        logic [3:0] cmd;
        logic [1:0] lv;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [3:0] cmds();
        return {kif.leftCmd, kif.rightCmd, kif.upCmd, kif.downCmd};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_hit();
        hitEnemy = 1'b1;
        @(posedge clk); #1;
        hitEnemy = 1'b0;
    endtask

    task automatic set_in(input logic r, input logic l, input logic c, input int y);
        onRope = r; onLedge = l; collision = c; topLeftY = 11'(y);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 200, S_GROUND, 4'b1110, 2'd3};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 200, S_AIR,    4'b1100, 2'd3};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 170, S_AIR,    4'b1100, 2'd3};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 150, S_AIR,    4'b1100, 2'd3};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 160, S_AIR,    4'b1100, 2'd3};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 240, S_GROUND, 4'b1110, 2'd3};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 240, S_ROPE,   4'b1111, 2'd3};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 150, S_AIR,    4'b1100, 2'd3};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 250, S_DYING,  4'b0000, 2'd2};

        startOfFrame = 0; restartPressed = 0; hitEnemy = 0;
        set_in(0, 0, 0, 185);
        kif.leftPressed = 1; kif.rightPressed = 1; kif.upPressed = 1; kif.downPressed = 1;
        do_reset();
        chk("reset state", state, S_AIR);
        chk("reset lives", lives, 3);
        chk("reset moveResetN", moveResetN, 1);
        chk("reset invincible", invincible, 0);
        chk("reset gameOver", gameOver, 0);
        chk("reset pulses", lows, 0);

        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].rope, tbl[i].ledge, tbl[i].coll, tbl[i].y);
            frame();
            chk($sformatf("row%0d state", i), state, tbl[i].st);
            chk($sformatf("row%0d cmds", i), cmds(), tbl[i].cmd);
            chk($sformatf("row%0d lives", i), lives, tbl[i].lv);
        end

        do_reset();
        set_in(0, 1, 1, 200);
        frame();
        chk("enemy pre state", state, S_GROUND);
        pulse_hit();
        frame();
        chk("enemy death state", state, S_DYING);
        chk("enemy death lives", lives, 2);
        l0 = lows;
        frames(59);
        chk("dying hold 59", state, S_DYING);
        frame();
        chk("dying to respawn", state, S_RESPAWN);
        chk("respawn pulse count", lows - l0, 1);
        chk("respawn pulse released", moveResetN, 1);
        chk("respawn invincible", invincible, 1);
        frame();
        chk("respawn to air", state, S_AIR);
        frame();
        chk("post respawn land", state, S_GROUND);
        pulse_hit();
        frame();
        chk("invincible hit state", state, S_GROUND);
        chk("invincible hit lives", lives, 2);
        frames(86);
        chk("invincible last frame", invincible, 1);
        frame();
        chk("invincible expired", invincible, 0);

        set_in(0, 0, 0, 100);
        frame();
        chk("drop to air", state, S_AIR);
        set_in(0, 1, 1, 250);
        pulse_hit();
        frame();
        chk("hit+fatal state", state, S_DYING);
        chk("hit+fatal lives", lives, 1);
        set_in(1, 0, 0, 200);
        frames(60);
        chk("second respawn", state, S_RESPAWN);
        frame();
        frame();
        chk("rope after respawn", state, S_ROPE);
        chk("rope cmds", cmds(), 4'b1111);
        topLeftY = 11'sd441;
        frame();
        chk("rope offscreen state", state, S_DYING);
        chk("third death lives", lives, 0);
        frames(60);
        chk("game over state", state, S_GAME_OVER);
        chk("game over flag", gameOver, 1);
        chk("game over cmds", cmds(), 4'b0000);
        frame();
        chk("game over hold", state, S_GAME_OVER);
        l0 = lows;
        restartPressed = 1;
        frame();
        restartPressed = 0;
        chk("restart state", state, S_RESPAWN);
        chk("restart lives", lives, 3);
        chk("restart pulse count", lows - l0, 1);

        set_in(0, 0, 0, 441);
        frame();
        frame();
        chk("air offscreen state", state, S_DYING);
        chk("air offscreen lives", lives, 2);
        frames(3);
        l0 = lows;
        #3 resetN = 1'b0;
        #1;
        chk("async reset state", state, S_AIR);
        chk("async reset lives", lives, 3);
        chk("async reset moveResetN", moveResetN, 1);
        chk("async reset invincible", invincible, 0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset no pulse", lows - l0, 0);
        chk("reset held air", state, S_AIR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/monkey_action_ctrl.md
MONKEY_ACTION_CTRL -- requirements
Module: monkey_action_ctrl

Interface
REQ-001 SHALL have parameter FALL_DEATH_PX, default 96, meaning the max survivable fall height in pixels (landing Y minus apex Y).
REQ-002 SHALL have parameter FLOOR_Y, default 440, meaning any topLeftY above this value is death by falling off-screen.
REQ-003 SHALL have parameter DEATH_FRAMES, default 60, meaning the number of frames spent in DYING.
REQ-004 SHALL have parameter INVULN_FRAMES, default 90, meaning the number of post-respawn frames that ignore hitEnemy.
REQ-005 SHALL have parameter START_LIVES, default 3, meaning the lives loaded at reset and at restart.
REQ-006 SHALL have port clk, input, 1 bit: system clock.
REQ-007 SHALL have port resetN, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port startOfFrame, input, 1 bit: one-clk pulse per frame.
REQ-009 SHALL have ports leftPressed, rightPressed, upPressed, downPressed, input, 1 bit each: raw keys.
REQ-010 SHALL have port restartPressed, input, 1 bit: leave GAME_OVER.
REQ-011 SHALL have ports onRope, onLedge, collision, input, 1 bit each: footing sources.
REQ-012 SHALL have port hitEnemy, input, 1 bit: enemy-overlap pulse, may be shorter than a frame.
REQ-013 SHALL have port topLeftY, input, signed 11 bits: monkey position from the movement block.
REQ-014 SHALL have ports leftCmd, rightCmd, upCmd, downCmd, output, 1 bit each: gated keys to the movement block.
REQ-015 SHALL have port moveResetN, output, 1 bit: active-low respawn pulse to the movement block.
REQ-016 SHALL have port state, output, 3 bits: current state encoding.
REQ-017 SHALL have port lives, output, 2 bits: remaining lives.
REQ-018 SHALL have port invincible, output, 1 bit: high while the invulnerability count is nonzero.
REQ-019 SHALL have port gameOver, output, 1 bit: high iff state is GAME_OVER.

Function
REQ-020 SHALL compute footing = onRope | (onLedge & collision).
REQ-021 SHALL provide states GROUND, ROPE, AIR, DYING, RESPAWN, GAME_OVER, with all transitions evaluated only on the startOfFrame cycle.
REQ-022 SHALL latch hitEnemy into a sticky flag (ignored while invincible), cleared on the startOfFrame cycle that consumes it.
REQ-023 SHALL make these transitions from GROUND, ROPE and AIR, in priority order:
- enemy flag set -> DYING;
- topLeftY > FLOOR_Y -> DYING;
- otherwise continue per REQ-024 to REQ-026.
REQ-024 SHALL, from GROUND or ROPE, go to ROPE if onRope, to GROUND if footing & !onRope, and to AIR if !footing, loading apexY <= topLeftY on entering AIR.
REQ-025 SHALL, while in AIR on each startOfFrame, update apexY <= min(apexY, topLeftY).
REQ-026 SHALL, when footing is seen in AIR:
- go to DYING if (topLeftY - apexY) > FALL_DEATH_PX, compared as a 12-bit signed difference;
- otherwise go to ROPE or GROUND per REQ-024.
REQ-027 SHALL, on entering DYING, decrement lives (saturating at 0) and load the frame counter with DEATH_FRAMES-1.
REQ-028 SHALL, in DYING, decrement the counter each frame; at 0, go to GAME_OVER if lives==0, else to RESPAWN.
REQ-029 SHALL, in RESPAWN, drive moveResetN low for exactly one clk (the first cycle in RESPAWN), load the invulnerability counter with INVULN_FRAMES, and go to AIR on the next startOfFrame with apexY <= topLeftY.
REQ-030 SHALL decrement the invulnerability counter once per startOfFrame while it is nonzero, in any state.
REQ-031 SHALL, in GAME_OVER with restartPressed on startOfFrame, reload lives <= START_LIVES and go to RESPAWN.
REQ-032 SHALL gate the command outputs combinationally from state:
- GROUND: left, right, up pass; down = 0.
- ROPE: all four pass.
- AIR: left, right pass; up, down = 0.
- DYING, RESPAWN, GAME_OVER: all 0.
REQ-033 SHALL give hitEnemy priority over landing when both occur in the same frame.

Reset
REQ-034 SHALL, on resetN low, asynchronously set:
- state = AIR, with apexY = 185 (the movement block's initial Y);
- lives = START_LIVES;
- both counters = 0 and the enemy flag = 0;
- moveResetN = 1, invincible = 0, gameOver = 0.
REQ-035 SHALL not emit a moveResetN pulse as a result of resetN.

Structure
REQ-036 SHALL define the state enum, its 3-bit encoding and the parameter defaults in the shared package monkey_pkg.
REQ-037 SHALL use one sub-module, frame_down_counter (load, enable on startOfFrame, zero flag), instantiated twice: once for DYING, once for invulnerability.

Verification
REQ-038 SHALL cover: reset, footing=1 via onLedge&collision, one frame -> state GROUND; upPressed -> upCmd=1, downPressed -> downCmd=0.
REQ-039 SHALL cover: footing drop at topLeftY=200 -> AIR; Y sweeps to 150 then lands at 240 (fall 90) -> GROUND; apex 150, land 250 (fall 100) -> DYING, lives 3->2.
REQ-040 SHALL cover: a 1-clk hitEnemy mid-frame in GROUND -> DYING at the next startOfFrame; after 60 frames -> RESPAWN; moveResetN low exactly 1 clk; invincible=1 for 90 frames.
REQ-041 SHALL cover: hitEnemy during invincibility -> no state change; a same-frame hitEnemy and fatal landing -> exactly one lives decrement.
REQ-042 SHALL cover: three deaths -> GAME_OVER, gameOver=1, all commands 0; restartPressed -> lives=3, RESPAWN pulse.
REQ-043 SHALL cover: topLeftY=441 in ROPE -> DYING; resetN asserted mid-DYING -> state AIR, lives=3, no moveResetN pulse.
